// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS memory-stage access unit. Takes one load/store/pass-through
// op at a time, runs it over a split-transaction (req/addr_ok/data_ok) bus, formats
// load data, builds store strobes and reports address-error / bus-timeout exceptions.
`timescale 1ns/1ps

module mem_access_unit #(
    parameter int ADDR_W       = 32,
    parameter bit UNALIGNED_EN = 1'b1,
    parameter int WAIT_LIMIT   = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_rt,
    input  logic [31:0]       in_passthru,
    input  logic [31:0]       in_pc,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [31:0]       out_pc,
    output logic [1:0]        out_exc,
    output logic [ADDR_W-1:0] out_badvaddr
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_CANCEL
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       rt_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              accept;
    logic              in_is_mem;
    logic              in_misaligned;
    logic              finish_data;
    logic              timeout;

    function automatic logic op_is_load(input logic [3:0] op);
        op_is_load = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: op_is_load = 1'b1;
            OP_LWL, OP_LWR:                      op_is_load = UNALIGNED_EN;
            default:                             op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        op_is_store = 1'b0;
        case (op)
            OP_SB, OP_SH, OP_SW: op_is_store = 1'b1;
            OP_SWL, OP_SWR:      op_is_store = UNALIGNED_EN;
            default:             op_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
        op_misaligned = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: op_misaligned = a[0];
            OP_LW, OP_SW:         op_misaligned = |a;
            default:              op_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_word(input logic [3:0] op);
        op_is_word = (op == OP_LW) || (op == OP_LWL) || (op == OP_LWR) ||
                     (op == OP_SW) || (op == OP_SWL) || (op == OP_SWR);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        op_size = 2'd2;
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
            default:              op_size = 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [3:0] op, input logic [1:0] a,
                                                input logic [31:0] r, input logic [31:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[{a, 3'b000} +: 8];
        h = a[1] ? r[31:16] : r[15:0];
        load_format = 32'h0;
        case (op)
            OP_LB:  load_format = {{24{b[7]}}, b};
            OP_LBU: load_format = {24'h0, b};
            OP_LH:  load_format = {{16{h[15]}}, h};
            OP_LHU: load_format = {16'h0, h};
            OP_LW:  load_format = r;
            OP_LWL:
                case (a)
                    2'd0:    load_format = {r[7:0], t[23:0]};
                    2'd1:    load_format = {r[15:0], t[15:0]};
                    2'd2:    load_format = {r[23:0], t[7:0]};
                    default: load_format = r;
                endcase
            OP_LWR:
                case (a)
                    2'd0:    load_format = r;
                    2'd1:    load_format = {t[31:24], r[31:8]};
                    2'd2:    load_format = {t[31:16], r[31:16]};
                    default: load_format = {t[31:8], r[31:24]};
                endcase
            default: load_format = 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [3:0] op, input logic [1:0] a);
        store_strobe = 4'b0000;
        case (op)
            OP_SB:  store_strobe = 4'b0001 << a;
            OP_SH:  store_strobe = a[1] ? 4'b1100 : 4'b0011;
            OP_SW:  store_strobe = 4'b1111;
            OP_SWL:
                case (a)
                    2'd0:    store_strobe = 4'b0001;
                    2'd1:    store_strobe = 4'b0011;
                    2'd2:    store_strobe = 4'b0111;
                    default: store_strobe = 4'b1111;
                endcase
            OP_SWR:
                case (a)
                    2'd0:    store_strobe = 4'b1111;
                    2'd1:    store_strobe = 4'b1110;
                    2'd2:    store_strobe = 4'b1100;
                    default: store_strobe = 4'b1000;
                endcase
            default: store_strobe = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] t);
        store_data = 32'h0;
        case (op)
            OP_SB:  store_data = {4{t[7:0]}};
            OP_SH:  store_data = {2{t[15:0]}};
            OP_SW:  store_data = t;
            OP_SWL:
                case (a)
                    2'd0:    store_data = {24'h0, t[31:24]};
                    2'd1:    store_data = {16'h0, t[31:16]};
                    2'd2:    store_data = {8'h0, t[31:8]};
                    default: store_data = t;
                endcase
            OP_SWR:
                case (a)
                    2'd0:    store_data = t;
                    2'd1:    store_data = {t[23:0], 8'h0};
                    2'd2:    store_data = {t[15:0], 16'h0};
                    default: store_data = {t[7:0], 24'h0};
                endcase
            default: store_data = 32'h0;
        endcase
    endfunction

    assign in_ready      = (state == S_IDLE) && !flush;
    assign accept        = in_valid && in_ready;
    assign in_is_mem     = op_is_load(in_op) || op_is_store(in_op);
    assign in_misaligned = in_is_mem && op_misaligned(in_op, in_addr[1:0]);
    assign bus_wr        = op_is_store(op_q);
    assign bus_size      = op_size(op_q);

    // Next-state decode; also flags the cycle a bus read completes or the wait times out
    always_comb begin
        next_state  = state;
        finish_data = 1'b0;
        timeout     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = (!in_is_mem || in_misaligned) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        next_state  = flush ? S_IDLE : S_DONE;
                        finish_data = !flush;
                    end else begin
                        next_state = flush ? S_CANCEL : S_WAIT;
                    end
                end else if (flush) begin
                    next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    next_state  = flush ? S_IDLE : S_DONE;
                    finish_data = !flush;
                end else if (flush) begin
                    next_state = S_CANCEL;
                end else if ((WAIT_LIMIT != 0) && (wait_cnt == CNT_LAST)) begin
                    next_state = S_DONE;
                    timeout    = 1'b1;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    next_state = S_IDLE;
                end
            end
            S_CANCEL: begin
                if (bus_data_ok) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counts consecutive WAIT cycles; cleared whenever the unit leaves or is not in WAIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT) && (next_state == S_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Latches the request and builds every registered output (bus side and result side)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q         <= 4'd0;
            addr_q       <= '0;
            rt_q         <= 32'h0;
            bus_req      <= 1'b0;
            bus_addr     <= '0;
            bus_wstrb    <= 4'b0000;
            bus_wdata    <= 32'h0;
            out_valid    <= 1'b0;
            out_result   <= 32'h0;
            out_pc       <= 32'h0;
            out_exc      <= 2'd0;
            out_badvaddr <= '0;
        end else begin
            bus_req   <= (next_state == S_REQ);
            out_valid <= (next_state == S_DONE);
            if (accept) begin
                op_q         <= in_op;
                addr_q       <= in_addr;
                rt_q         <= in_rt;
                out_pc       <= in_pc;
                bus_addr     <= op_is_word(in_op) ? {in_addr[ADDR_W-1:2], 2'b00} : in_addr;
                bus_wstrb    <= op_is_store(in_op) ? store_strobe(in_op, in_addr[1:0]) : 4'b0000;
                bus_wdata    <= op_is_store(in_op) ? store_data(in_op, in_addr[1:0], in_rt) : 32'h0;
                out_result   <= in_is_mem ? 32'h0 : in_passthru;
                out_exc      <= in_misaligned ? (op_is_store(in_op) ? 2'd2 : 2'd1) : 2'd0;
                out_badvaddr <= in_misaligned ? in_addr : '0;
            end
            if (finish_data) begin
                out_result <= op_is_load(op_q) ? load_format(op_q, addr_q[1:0], bus_rdata, rt_q) : 32'h0;
            end
            if (timeout) begin
                out_result   <= 32'h0;
                out_exc      <= 2'd3;
                out_badvaddr <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed, table-driven bench for mem_access_unit with
// hand-written sequences for timeout, flush, async reset and output back-pressure.
`timescale 1ns/1ps

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_rt;
    logic [31:0] in_passthru;
    logic [31:0] in_pc;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_pc;
    logic [1:0]  out_exc;
    logic [31:0] out_badvaddr;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] passthru;
        logic [31:0] rdata;
        logic        exp_bus;
        logic [31:0] exp_addr;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_result;
        logic [1:0]  exp_exc;
        logic [31:0] exp_bad;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    mem_access_unit #(
        .ADDR_W      (32),
        .UNALIGNED_EN(1'b1),
        .WAIT_LIMIT  (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .in_rt       (in_rt),
        .in_passthru (in_passthru),
        .in_pc       (in_pc),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wstrb   (bus_wstrb),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_pc      (out_pc),
        .out_exc     (out_exc),
        .out_badvaddr(out_badvaddr)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Hard stop in case the bench ever loses its way
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] pt, input logic [31:0] pc);
        in_op       = op;
        in_addr     = addr;
        in_rt       = rt;
        in_passthru = pt;
        in_pc       = pc;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input logic [31:0] pc, input int idx);
        checkOutput($sformatf("v%0d_in_ready_idle", idx), in_ready, 1);
        present(v.op, v.addr, v.rt, v.passthru, pc);
        if (v.exp_bus) begin
            checkOutput($sformatf("v%0d_bus_req", idx), bus_req, 1);
            checkOutput($sformatf("v%0d_bus_addr", idx), bus_addr, v.exp_addr);
            checkOutput($sformatf("v%0d_bus_wr", idx), bus_wr, v.exp_wr);
            checkOutput($sformatf("v%0d_bus_size", idx), bus_size, v.exp_size);
            checkOutput($sformatf("v%0d_bus_wstrb", idx), bus_wstrb, v.exp_wstrb);
            if (v.exp_wr) checkOutput($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.exp_wdata);
            checkOutput($sformatf("v%0d_valid_in_req", idx), out_valid, 0);
            bus_addr_ok = 1'b1;
            tick();
            bus_addr_ok = 1'b0;
            checkOutput($sformatf("v%0d_bus_req_wait", idx), bus_req, 0);
            checkOutput($sformatf("v%0d_valid_in_wait", idx), out_valid, 0);
            bus_data_ok = 1'b1;
            bus_rdata   = v.rdata;
            tick();
            bus_data_ok = 1'b0;
            bus_rdata   = 32'h0;
        end else begin
            checkOutput($sformatf("v%0d_no_bus_req", idx), bus_req, 0);
        end
        checkOutput($sformatf("v%0d_out_valid", idx), out_valid, 1);
        checkOutput($sformatf("v%0d_out_result", idx), out_result, v.exp_result);
        checkOutput($sformatf("v%0d_out_exc", idx), out_exc, v.exp_exc);
        checkOutput($sformatf("v%0d_out_badvaddr", idx), out_badvaddr, v.exp_bad);
        checkOutput($sformatf("v%0d_out_pc", idx), out_pc, pc);
        checkOutput($sformatf("v%0d_in_ready_busy", idx), in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput($sformatf("v%0d_valid_drop", idx), out_valid, 0);
        checkOutput($sformatf("v%0d_in_ready_back", idx), in_ready, 1);
    endtask

    // Main sequence: reset checks, vector table, then multi-cycle corner cases
    initial begin
        // op, addr, rt, passthru, rdata, exp_bus, exp_addr, exp_wr, exp_size, exp_wstrb, exp_wdata, exp_result, exp_exc, exp_bad
        vecs[0]  = '{4'd0,  32'h1003, 32'h0, 32'h0, 32'h80FF_0000, 1'b1, 32'h1003, 1'b0, 2'd0, 4'b0000, 32'h0, 32'hFFFF_FF80, 2'd0, 32'h0};
        vecs[1]  = '{4'd1,  32'h1002, 32'h0, 32'h0, 32'h12A4_5678, 1'b1, 32'h1002, 1'b0, 2'd0, 4'b0000, 32'h0, 32'h0000_00A4, 2'd0, 32'h0};
        vecs[2]  = '{4'd2,  32'h1002, 32'h0, 32'h0, 32'h8001_7FFF, 1'b1, 32'h1002, 1'b0, 2'd1, 4'b0000, 32'h0, 32'hFFFF_8001, 2'd0, 32'h0};
        vecs[3]  = '{4'd3,  32'h1000, 32'h0, 32'h0, 32'h1234_F00D, 1'b1, 32'h1000, 1'b0, 2'd1, 4'b0000, 32'h0, 32'h0000_F00D, 2'd0, 32'h0};
        vecs[4]  = '{4'd4,  32'h1008, 32'h0, 32'h0, 32'hCAFE_BABE, 1'b1, 32'h1008, 1'b0, 2'd2, 4'b0000, 32'h0, 32'hCAFE_BABE, 2'd0, 32'h0};
        vecs[5]  = '{4'd5,  32'h2002, 32'h5566_7788, 32'h0, 32'h1122_3344, 1'b1, 32'h2000, 1'b0, 2'd2, 4'b0000, 32'h0, 32'h2233_4488, 2'd0, 32'h0};
        vecs[6]  = '{4'd6,  32'h2001, 32'h5566_7788, 32'h0, 32'h1122_3344, 1'b1, 32'h2000, 1'b0, 2'd2, 4'b0000, 32'h0, 32'h5511_2233, 2'd0, 32'h0};
        vecs[7]  = '{4'd5,  32'h2000, 32'h5566_7788, 32'h0, 32'h1122_3344, 1'b1, 32'h2000, 1'b0, 2'd2, 4'b0000, 32'h0, 32'h4466_7788, 2'd0, 32'h0};
        vecs[8]  = '{4'd6,  32'h2003, 32'h5566_7788, 32'h0, 32'h1122_3344, 1'b1, 32'h2000, 1'b0, 2'd2, 4'b0000, 32'h0, 32'h5566_7711, 2'd0, 32'h0};
        vecs[9]  = '{4'd8,  32'h3002, 32'h0000_00A5, 32'h0, 32'h0, 1'b1, 32'h3002, 1'b1, 2'd0, 4'b0100, 32'hA5A5_A5A5, 32'h0, 2'd0, 32'h0};
        vecs[10] = '{4'd9,  32'h3002, 32'h1234_BEEF, 32'h0, 32'h0, 1'b1, 32'h3002, 1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 2'd0, 32'h0};
        vecs[11] = '{4'd10, 32'h3004, 32'h0102_0304, 32'h0, 32'h0, 1'b1, 32'h3004, 1'b1, 2'd2, 4'b1111, 32'h0102_0304, 32'h0, 2'd0, 32'h0};
        vecs[12] = '{4'd11, 32'h3005, 32'hAABB_CCDD, 32'h0, 32'h0, 1'b1, 32'h3004, 1'b1, 2'd2, 4'b0011, 32'h0000_AABB, 32'h0, 2'd0, 32'h0};
        vecs[13] = '{4'd12, 32'h2001, 32'hAABB_CCDD, 32'h0, 32'h0, 1'b1, 32'h2000, 1'b1, 2'd2, 4'b1110, 32'hBBCC_DD00, 32'h0, 2'd0, 32'h0};
        vecs[14] = '{4'd12, 32'h3003, 32'hAABB_CCDD, 32'h0, 32'h0, 1'b1, 32'h3000, 1'b1, 2'd2, 4'b1000, 32'hDD00_0000, 32'h0, 2'd0, 32'h0};
        vecs[15] = '{4'd4,  32'h3002, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 32'h0, 2'd1, 32'h3002};
        vecs[16] = '{4'd9,  32'h3001, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 32'h0, 2'd2, 32'h3001};
        vecs[17] = '{4'd2,  32'h3003, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 32'h0, 2'd1, 32'h3003};
        vecs[18] = '{4'd10, 32'h3006, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 32'h0, 2'd2, 32'h3006};
        vecs[19] = '{4'd7,  32'h0,    32'h0, 32'h1357_9BDF, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 32'h1357_9BDF, 2'd0, 32'h0};

        resetn      = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 4'd0;
        in_addr     = 32'h0;
        in_rt       = 32'h0;
        in_passthru = 32'h0;
        in_pc       = 32'h0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        out_ready   = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_bus_req", bus_req, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_pc", out_pc, 0);
        checkOutput("rst_out_exc", out_exc, 0);
        checkOutput("rst_out_badvaddr", out_badvaddr, 0);
        checkOutput("rst_bus_addr", bus_addr, 0);
        checkOutput("rst_bus_wstrb", bus_wstrb, 0);
        checkOutput("rst_bus_wdata", bus_wdata, 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], 32'hBFC0_0000 + 32'(i * 4), i);
        end

        present(4'd4, 32'h1010, 32'h0, 32'h0, 32'h8000_0010);
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h0BAD_F00D;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        checkOutput("same_cycle_valid", out_valid, 1);
        checkOutput("same_cycle_result", out_result, 32'h0BAD_F00D);
        checkOutput("same_cycle_bus_req", bus_req, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        present(4'd4, 32'h4000, 32'h0, 32'h0, 32'h8000_0040);
        checkOutput("to_bus_req", bus_req, 1);
        checkOutput("to_bus_addr", bus_addr, 32'h4000);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("to_wait%0d_valid", k), out_valid, 0);
            tick();
        end
        checkOutput("to_valid", out_valid, 1);
        checkOutput("to_exc", out_exc, 3);
        checkOutput("to_badvaddr", out_badvaddr, 32'h4000);
        checkOutput("to_result", out_result, 0);
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hFFFF_FFFF;
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        checkOutput("late_ok_valid", out_valid, 1);
        checkOutput("late_ok_exc", out_exc, 3);
        checkOutput("late_ok_result", out_result, 0);
        checkOutput("late_ok_badvaddr", out_badvaddr, 32'h4000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("to_valid_drop", out_valid, 0);

        present(4'd4, 32'h5000, 32'h0, 32'h0, 32'h8000_0050);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fw_cancel_valid", out_valid, 0);
        checkOutput("fw_cancel_in_ready", in_ready, 0);
        tick();
        checkOutput("fw_cancel2_valid", out_valid, 0);
        checkOutput("fw_cancel2_in_ready", in_ready, 0);
        bus_data_ok = 1'b1;
        tick();
        bus_data_ok = 1'b0;
        checkOutput("fw_in_ready_back", in_ready, 1);
        checkOutput("fw_valid_never", out_valid, 0);

        present(4'd4, 32'h7000, 32'h0, 32'h0, 32'h8000_0070);
        checkOutput("fr_bus_req", bus_req, 1);
        flush = 1'b1;
        tick();
        checkOutput("fr_bus_req_drop", bus_req, 0);
        checkOutput("fr_in_ready_flush", in_ready, 0);
        flush = 1'b0;
        #1;
        checkOutput("fr_in_ready_idle", in_ready, 1);
        checkOutput("fr_valid", out_valid, 0);

        present(4'd7, 32'h0, 32'h0, 32'h1111_1111, 32'h8000_0080);
        checkOutput("fd_valid", out_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checkOutput("fd_valid_drop", out_valid, 0);
        checkOutput("fd_in_ready", in_ready, 1);

        present(4'd15, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h8000_0090);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("hold%0d_valid", k), out_valid, 1);
            checkOutput($sformatf("hold%0d_result", k), out_result, 32'hDEAD_BEEF);
            checkOutput($sformatf("hold%0d_in_ready", k), in_ready, 0);
            tick();
        end
        checkOutput("hold_end_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("hold_valid_drop", out_valid, 0);
        checkOutput("hold_in_ready", in_ready, 1);

        present(4'd10, 32'h6000, 32'h1234_5678, 32'h0, 32'h8000_0060);
        checkOutput("ar_bus_req", bus_req, 1);
        checkOutput("ar_bus_wdata", bus_wdata, 32'h1234_5678);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("ar_bus_req_drop", bus_req, 0);
        checkOutput("ar_bus_addr", bus_addr, 0);
        checkOutput("ar_bus_wstrb", bus_wstrb, 0);
        checkOutput("ar_bus_wdata0", bus_wdata, 0);
        checkOutput("ar_out_pc", out_pc, 0);
        checkOutput("ar_out_valid", out_valid, 0);
        checkOutput("ar_in_ready", in_ready, 1);
        #1;
        resetn = 1'b1;
        tick();
        checkOutput("ar_after_bus_req", bus_req, 0);
        checkOutput("ar_after_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
